// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Double-buffered frame (BCD, DP, enables) swapped only at frame boundaries, with leading-zero blanking.
module seven_seg_scan_controller #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  mask_in,
   input  logic        load,
   input  logic        blank_lz,
   output logic [7:0]  light_on,
   output logic [3:0]  BCD,
   output logic        DP,
   output logic        load_ack,
   output logic        frame_tick
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic [2:0]       idx_nxt;
   logic             slot_tick;
   logic             boundary;
   logic             xfer;

   logic [31:0] pend_digits, act_digits, act_digits_nxt;
   logic [7:0]  pend_dp, act_dp, act_dp_nxt;
   logic [7:0]  pend_mask, act_mask, act_mask_nxt;
   logic        pend_valid;

   logic [7:0]  zero_run;
   logic        run;
   logic        lit;
   logic [3:0]  sel_digit;
   logic [7:0]  light_nxt;
   logic [3:0]  bcd_nxt;
   logic        dp_nxt;

   // Handshake: load is a request sampled every cycle (last one wins); load_ack is a
   // one-cycle pulse in the cycle the captured frame starts showing at slot 0.
   always_comb begin
      slot_tick      = (div_cnt == DIV_LAST);
      boundary       = slot_tick && (idx == 3'd7);
      xfer           = boundary && (load || pend_valid);
      idx_nxt        = idx + 3'd1;
      act_digits_nxt = act_digits;
      act_dp_nxt     = act_dp;
      act_mask_nxt   = act_mask;
      if (boundary && load) begin
         act_digits_nxt = digits_in;
         act_dp_nxt     = dp_in;
         act_mask_nxt   = mask_in;
      end else if (boundary && pend_valid) begin
         act_digits_nxt = pend_digits;
         act_dp_nxt     = pend_dp;
         act_mask_nxt   = pend_mask;
      end
   end

   // zero_run[i]: every enabled digit from i up to 7 is zero (disabled digits are skipped).
   always_comb begin
      run      = 1'b1;
      zero_run = '0;
      for (int j = 7; j >= 0; j--) begin
         run = run & (~act_mask_nxt[j] | (act_digits_nxt[4*j +: 4] == 4'd0));
         zero_run[j] = run;
      end
      sel_digit = act_digits_nxt[{idx_nxt, 2'b00} +: 4];
      lit       = act_mask_nxt[idx_nxt] &&
                  !(blank_lz && (idx_nxt != 3'd0) && zero_run[idx_nxt]);
      light_nxt = lit ? (8'd1 << idx_nxt) : 8'd0;
      bcd_nxt   = lit ? sel_digit : 4'hF;
      dp_nxt    = lit & act_dp_nxt[idx_nxt];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt     <= '0;
         idx         <= 3'd0;
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_mask   <= '0;
         pend_valid  <= 1'b0;
         act_digits  <= '0;
         act_dp      <= '0;
         act_mask    <= '0;
         light_on    <= 8'd0;
         BCD         <= 4'hF;
         DP          <= 1'b0;
         load_ack    <= 1'b0;
         frame_tick  <= 1'b0;
      end else begin
         div_cnt    <= slot_tick ? '0 : div_cnt + DIV_W'(1);
         frame_tick <= boundary;
         load_ack   <= xfer;
         act_digits <= act_digits_nxt;
         act_dp     <= act_dp_nxt;
         act_mask   <= act_mask_nxt;
         if (load) begin
            pend_digits <= digits_in;
            pend_dp     <= dp_in;
            pend_mask   <= mask_in;
         end
         // A boundary always empties pending: either it transfers or a same-cycle load bypasses it.
         if (boundary)
            pend_valid <= 1'b0;
         else if (load)
            pend_valid <= 1'b1;
         if (slot_tick) begin
            idx      <= idx_nxt;
            light_on <= light_nxt;
            BCD      <= bcd_nxt;
            DP       <= dp_nxt;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller with SCAN_DIV=4 (32-cycle frames).
// Outputs are sampled on the falling edge; each frame is compared slot-by-slot against hand-written vectors.
module tb_seven_seg_scan_controller;

   logic        clk;
   logic        rst;
   logic [31:0] digits_in;
   logic [7:0]  dp_in;
   logic [7:0]  mask_in;
   logic        load;
   logic        blank_lz;
   logic [7:0]  light_on;
   logic [3:0]  BCD;
   logic        DP;
   logic        load_ack;
   logic        frame_tick;

   int n_checks = 0;
   int n_pass   = 0;
   logic [12:0] exp_q[$];

   seven_seg_scan_controller #(.SCAN_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .mask_in    (mask_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .light_on   (light_on),
      .BCD        (BCD),
      .DP         (DP),
      .load_ack   (load_ack),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   // One slot lasts 4 cycles; expectation packs {light_on, BCD, DP}.
   task automatic push_slot(input logic [7:0] l, input logic [3:0] b, input logic d);
      repeat (4) exp_q.push_back({l, b, d});
   endtask

   task automatic push_dark(input int n);
      repeat (n) push_slot(8'h00, 4'hF, 1'b0);
   endtask

   task automatic drive_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
      digits_in = d;
      dp_in     = p;
      mask_in   = m;
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (!load_ack && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ack"}, 32'(load_ack), 32'd1);
      check({tag, "_ft"}, 32'(frame_tick), 32'd1);
   endtask

   // Starts at frame cycle 0 (current negedge) and ends at frame cycle 31.
   task automatic scan_frame(input string tag);
      int extra_ack = 0;
      for (int i = 0; i < 32; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (load_ack) extra_ack++;
         end
         check(tag, 32'({light_on, BCD, DP}), 32'(exp_q.pop_front()));
      end
      check({tag, "_no_extra_ack"}, 32'(extra_ack), 32'd0);
   endtask

   initial begin
      int dark_bad, ack_cnt, ft_cnt, ft_first, ft_last;
      rst = 1'b1; digits_in = '0; dp_in = '0; mask_in = '0; load = 1'b0; blank_lz = 1'b0;

      // Reset and dark display
      repeat (3) @(negedge clk);
      check("rst_light", 32'(light_on), 32'h00);
      check("rst_bcd", 32'(BCD), 32'hF);
      check("rst_dp", 32'(DP), 32'd0);
      check("rst_ack", 32'(load_ack), 32'd0);
      check("rst_ft", 32'(frame_tick), 32'd0);
      rst = 1'b0;
      dark_bad = 0; ack_cnt = 0; ft_cnt = 0; ft_first = 0; ft_last = 0;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (light_on != 8'h00 || BCD != 4'hF || DP) dark_bad++;
         if (load_ack) ack_cnt++;
         if (frame_tick) begin
            ft_cnt++;
            if (ft_first == 0) ft_first = c;
            ft_last = c;
         end
      end
      check("dark_cycles", 32'(dark_bad), 32'd0);
      check("dark_acks", 32'(ack_cnt), 32'd0);
      check("ft_count", 32'(ft_cnt), 32'd2);
      check("ft_first", 32'(ft_first), 32'd32);
      check("ft_last", 32'(ft_last), 32'd64);

      // Basic scan
      drive_load(32'h76543210, 8'h04, 8'hFF);
      wait_ack("basic");
      push_slot(8'h01, 4'h0, 1'b0); push_slot(8'h02, 4'h1, 1'b0);
      push_slot(8'h04, 4'h2, 1'b1); push_slot(8'h08, 4'h3, 1'b0);
      push_slot(8'h10, 4'h4, 1'b0); push_slot(8'h20, 4'h5, 1'b0);
      push_slot(8'h40, 4'h6, 1'b0); push_slot(8'h80, 4'h7, 1'b0);
      scan_frame("basic_scan");

      // Leading-zero blanking, then blanking off
      @(negedge clk);
      blank_lz = 1'b1;
      drive_load(32'h00000105, 8'h00, 8'hFF);
      wait_ack("lz");
      push_slot(8'h01, 4'h5, 1'b0); push_slot(8'h02, 4'h0, 1'b0);
      push_slot(8'h04, 4'h1, 1'b0); push_dark(5);
      scan_frame("lz_on");
      blank_lz = 1'b0;
      @(negedge clk);
      push_slot(8'h01, 4'h5, 1'b0); push_slot(8'h02, 4'h0, 1'b0);
      push_slot(8'h04, 4'h1, 1'b0); push_slot(8'h08, 4'h0, 1'b0);
      push_slot(8'h10, 4'h0, 1'b0); push_slot(8'h20, 4'h0, 1'b0);
      push_slot(8'h40, 4'h0, 1'b0); push_slot(8'h80, 4'h0, 1'b0);
      scan_frame("lz_off");

      // All-zero frame with digit 7 disabled
      @(negedge clk);
      blank_lz = 1'b1;
      drive_load(32'h00000000, 8'h00, 8'h7F);
      wait_ack("mask");
      push_slot(8'h01, 4'h0, 1'b0); push_dark(7);
      scan_frame("mask_zero");

      // Two loads in one frame: only the second is shown, one ack
      @(negedge clk);
      blank_lz = 1'b0;
      drive_load(32'h11111111, 8'h00, 8'hFF);
      @(negedge clk);
      drive_load(32'hFEDCBA98, 8'h81, 8'hFF);
      wait_ack("race");
      push_slot(8'h01, 4'h8, 1'b1); push_slot(8'h02, 4'h9, 1'b0);
      push_slot(8'h04, 4'hA, 1'b0); push_slot(8'h08, 4'hB, 1'b0);
      push_slot(8'h10, 4'hC, 1'b0); push_slot(8'h20, 4'hD, 1'b0);
      push_slot(8'h40, 4'hE, 1'b0); push_slot(8'h80, 4'hF, 1'b1);
      scan_frame("race_b");
      @(negedge clk);
      check("race_no_dup_ack", 32'(load_ack), 32'd0);
      check("race_ft", 32'(frame_tick), 32'd1);
      repeat (31) @(negedge clk);

      // Load on the boundary cycle itself: ack one cycle later with slot 0 shown
      drive_load(32'h31415926, 8'h10, 8'h0F);
      check("bnd_ack", 32'(load_ack), 32'd1);
      check("bnd_ft", 32'(frame_tick), 32'd1);
      push_slot(8'h01, 4'h6, 1'b0); push_slot(8'h02, 4'h2, 1'b0);
      push_slot(8'h04, 4'h9, 1'b0); push_slot(8'h08, 4'h5, 1'b0);
      push_dark(4);
      scan_frame("bnd_frame");

      // Async reset mid-frame with a pending load
      @(negedge clk);
      drive_load(32'h77777777, 8'hFF, 8'hFF);
      repeat (12) @(negedge clk);
      check("pre_rst_light", 32'(light_on), 32'h08);
      #2 rst = 1'b1;
      #1;
      check("async_light", 32'(light_on), 32'h00);
      check("async_bcd", 32'(BCD), 32'hF);
      check("async_dp", 32'(DP), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dark_bad = 0; ack_cnt = 0; ft_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (light_on != 8'h00 || BCD != 4'hF || DP) dark_bad++;
         if (load_ack) ack_cnt++;
         if (frame_tick) ft_cnt++;
      end
      check("post_rst_dark", 32'(dark_bad), 32'd0);
      check("post_rst_no_ack", 32'(ack_cnt), 32'd0);
      check("post_rst_ft", 32'(ft_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_controller.md
# seven_seg_scan_controller

Time-multiplexed scan controller for the 8-digit seven-segment display on the traffic-light board. It sits between the counter/traffic logic and the seven-segment decoder. It holds a double-buffered 8-digit frame of BCD digits, DP bits and digit enables, and steps one digit at a time at a programmable rate. Each step it drives the decoder's one-hot digit select, BCD and DP inputs, with optional leading-zero blanking. New frames are accepted with a load/ack handshake and take effect only at a frame boundary, so the display never tears.

## Interface
- SCAN_DIV, default 100000: clock cycles per digit slot. Legal range is 2..2^24.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- digits_in  in  32  frame BCD; nibble i ([4i+3:4i]) is digit i, digit 7 most significant
- dp_in  in  8  decimal point per digit, active-high
- mask_in  in  8  digit enable per digit, active-high
- load  in  1  single-cycle request to capture digits_in/dp_in/mask_in
- blank_lz  in  1  leading-zero blanking enable, level, sampled every slot
- light_on  out  8  one-hot active-high digit select to decoder (0 = all dark)
- BCD  out  4  digit code to decoder; 4'hF when dark/blanked
- DP  out  1  decimal point to decoder, active-high
- load_ack  out  1  one-cycle pulse when a captured frame becomes active
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- **Prescaler.**
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - slot_tick = (div_cnt == SCAN_DIV-1).
- **Scan index.**
  - idx (3 bits) increments mod 8 on slot_tick.
  - The frame boundary is slot_tick with idx == 7. On that cycle frame_tick = 1, registered so it is visible the following cycle.
- **Frame buffers.**
  - The pending register plus pend_valid flag and the active register each hold 32+8+8 bits.
  - load = 1 captures the inputs into pending and sets pend_valid.
  - A later load before transfer overwrites pending; only the last one survives.
  - At a frame boundary with pend_valid = 1, pending is copied to active, pend_valid is cleared, and load_ack pulses the next cycle.
  - load on the same cycle as a frame boundary: the input values go directly to active, pend_valid ends 0, and load_ack pulses once.
  - No transfer at a boundary with pend_valid = 0, so no ack.
- **Leading-zero blanking.**
  - Digit i (i ≥ 1) is blanked when blank_lz = 1 and every digit j in i..7 that is enabled in the active mask has BCD 0.
  - Digit 0 is never blanked.
  - Disabled digits do not break a zero run.
- **Output select (for slot idx).**
  - If mask[idx] = 1 and the digit is not blanked: light_on = 1<<idx, BCD = active nibble, DP = active dp[idx].
  - Otherwise: light_on = 0, BCD = 4'hF, DP = 0.
  - BCD values 10..15 pass through unchanged (10 renders as '-').
- **Reset values.** All of the following are 0 while rst is high: div_cnt, idx, pending, pend_valid, active, light_on, DP, load_ack, frame_tick. BCD = 4'hF. The display is dark until the first frame transfer.
- **Reset mid-operation.** Asserting rst at any point aborts the current scan and discards both pending and active; no ack is issued.

## Timing
- All outputs are registered.
- light_on/BCD/DP change exactly 1 cycle after the slot_tick that changes idx. Each digit is held for SCAN_DIV cycles.
- After rst deasserts, slot 0 is presented. The first slot_tick occurs SCAN_DIV-1 cycles later, at the first cycle with div_cnt = SCAN_DIV-1.
- Frame period is 8·SCAN_DIV cycles, measured frame_tick to frame_tick.
- Load-to-active latency:
  - minimum 1 cycle (load on the boundary cycle);
  - maximum 8·SCAN_DIV cycles.
  - load_ack and the first output from the new frame (slot 0) appear in the same cycle.
- load is level-sampled every cycle; holding it high for N cycles equals N consecutive loads.

## Test plan
- **Reset/dark.** SCAN_DIV=4; hold rst 3 cycles then release, no load → light_on=0, BCD=4'hF, DP=0 for 64 cycles; frame_tick every 32 cycles; load_ack never pulses.
- **Basic scan.** Load digits 0x76543210, dp=8'h04, mask=8'hFF → load_ack at the next boundary. Then light_on steps 01,02,04,…,80 every 4 cycles; BCD follows 0..7; DP=1 only while light_on=8'h04.
- **Leading-zero blank.** Load digits 0x00000105, mask=8'hFF, blank_lz=1 → digits 3..7 dark (light_on=0, BCD=F); digits 0,1,2 show 5,0,1. With blank_lz=0, all 8 are lit.
- **Mask/zero.** Load digits 0x00000000, mask=8'h7F, blank_lz=1 → only digit 0 lit, showing 0; digit 7 is never lit.
- **Handshake races.**
  - Two loads (A then B) within one frame → a single ack; B is displayed.
  - A load on the exact boundary cycle → ack next cycle; the new frame shows from slot 0.
- **Async reset mid-frame.** Assert rst at slot 3 while pend_valid=1 → outputs go to reset values immediately, with no clock edge needed. After release the display stays dark and no ack follows.
